// File: rtl/tow_key_conditioner.sv
// tow_key_conditioner
//   Input stage of the tug-of-war playfield. Each raw, asynchronous, bouncy,
//   active-low player key is synchronised and debounced. The block emits one
//   single-cycle registered press pulse per accepted press, however long the
//   key is held or however much it bounces.
// Ports
//   clk      system clock, all logic on posedge
//   reset    synchronous active-high reset
//   key_l_n  raw left key, active low, asynchronous
//   key_r_n  raw right key, active low, asynchronous
//   enable   0 suppresses pulses; the FSMs keep tracking the keys
//   L, R     left/right press pulse, one cycle, registered
//   held_l   left FSM in HELD or REL_WAIT, registered
//   held_r   right FSM in HELD or REL_WAIT, registered
module tow_key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key_l_n,
  input  logic key_r_n,
  input  logic enable,
  output logic L,
  output logic R,
  output logic held_l,
  output logic held_r
);

  localparam int unsigned NCH = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } state_t;

  // Channel 0 = left, channel 1 = right
  logic [NCH-1:0] key_n;
  logic [NCH-1:0] sync1;
  logic [NCH-1:0] sync2;
  logic [NCH-1:0] pressed;

  state_t           state_q [NCH];
  state_t           state_d [NCH];
  logic [CNT_W-1:0] cnt_q   [NCH];
  logic [CNT_W-1:0] cnt_d   [NCH];
  logic [NCH-1:0]   pulse_q;
  logic [NCH-1:0]   pulse_d;
  logic [NCH-1:0]   held_q;
  logic [NCH-1:0]   held_d;

  assign key_n = {key_r_n, key_l_n};

  // Two-flop synchroniser; resets to the released level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign pressed = ~sync2;

  // State, counter and output registers for both channels
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      pulse_q <= '0;
      held_q  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      pulse_q <= pulse_d;
      held_q  <= held_d;
    end
  end

  // Debounce FSM per channel; pulse only on the PRESS_WAIT -> HELD transition
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      pulse_d[i] = 1'b0;
      held_d[i]  = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (pressed[i]) begin
            state_d[i] = PRESS_WAIT;
            cnt_d[i]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!pressed[i]) begin
            state_d[i] = IDLE;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = HELD;
            pulse_d[i] = enable;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        HELD: begin
          if (!pressed[i]) begin
            state_d[i] = REL_WAIT;
            cnt_d[i]   = '0;
          end
        end
        REL_WAIT: begin
          // Re-press during release debounce is bounce: back to HELD, no pulse
          if (pressed[i]) begin
            state_d[i] = HELD;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
      held_d[i] = (state_d[i] == HELD) || (state_d[i] == REL_WAIT);
    end
  end

  assign L      = pulse_q[0];
  assign R      = pulse_q[1];
  assign held_l = held_q[0];
  assign held_r = held_q[1];

endmodule
